// File: rtl/borus_ctrl_pkg.sv
// Shared definitions for the BorusCPU run controller: command codes,
// controller state encoding, default widths and a small state helper.
package borus_ctrl_pkg;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_ABORT = 2'd3;

    localparam int DEF_PROG_DEPTH = 16;
    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_CYC_W      = 16;
    localparam int DEF_MAX_CYCLES = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSED,
        ST_RUN,
        ST_STEP,
        ST_HALTED
    } state_t;

    // RUN and STEP may only be started from a reset or paused core
    function automatic logic can_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/borus_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable and the
// count sticks at all-ones instead of wrapping.
module borus_sat_counter #(
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count
);

    // count enabled cycles, holding at the top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/borus_run_ctrl.sv
// Host-facing run controller for the BorusCPU core: loads program bytes,
// drives core reset / clock enable, tracks halt, counts cycles and times out.
// Optional breakpoint support is built when BORUS_RUN_CTRL_BKPT_EN is defined.
module borus_run_ctrl
    import borus_ctrl_pkg::*;
#(
    parameter int PROG_DEPTH = DEF_PROG_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CYC_W      = DEF_CYC_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_ce,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [CYC_W-1:0]  cycles
`ifdef BORUS_RUN_CTRL_BKPT_EN
    ,
    input  logic [7:0]        cpu_pc,
    input  logic [7:0]        bkpt_addr,
    input  logic              bkpt_on
`endif
);

    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [CYC_W-1:0]  LIMIT_M1  = CYC_W'(MAX_CYCLES - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              accept;
    logic              abort_now;
    logic              we_nxt, done_nxt, err_nxt, timeout_nxt;
    logic              cnt_clear;
    logic              bkpt_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign abort_now = accept && (cmd_op == OP_ABORT) && (state != ST_IDLE);
    assign cmd_ready = (state != ST_STEP);
    assign cpu_rst   = (state == ST_IDLE);
    assign busy      = (state == ST_RUN) || (state == ST_STEP);
    assign cpu_ce    = ((state == ST_RUN) && !cpu_halted && !bkpt_hit) || (state == ST_STEP);

`ifdef BORUS_RUN_CTRL_BKPT_EN
    logic bkpt_skip;

    assign bkpt_hit = bkpt_on && (cpu_pc == bkpt_addr) && !bkpt_skip;

    // resuming from a pause lets the first instruction through even if it sits on the breakpoint
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bkpt_skip <= 1'b0;
        end else if (accept && (cmd_op == OP_RUN) && (state == ST_PAUSED)) begin
            bkpt_skip <= 1'b1;
        end else if (state == ST_RUN) begin
            bkpt_skip <= 1'b0;
        end
    end
`else
    assign bkpt_hit = 1'b0;
`endif

    // command decode first, then run/step progress unless an abort takes over
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        we_nxt      = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        timeout_nxt = timeout;
        cnt_clear   = 1'b0;

        if (accept) begin
            timeout_nxt = 1'b0;
            case (cmd_op)
                OP_LOAD: begin
                    if (state == ST_RUN) begin
                        err_nxt = 1'b1;
                    end else begin
                        we_nxt    = 1'b1;
                        ptr_nxt   = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_clear = 1'b1;
                    end
                end
                OP_RUN: begin
                    if (can_start(state)) state_nxt = ST_RUN;
                    else                  err_nxt   = 1'b1;
                end
                OP_STEP: begin
                    if (can_start(state)) state_nxt = ST_STEP;
                    else                  err_nxt   = 1'b1;
                end
                default: begin
                    if (state != ST_IDLE) begin
                        state_nxt = ST_IDLE;
                        ptr_nxt   = '0;
                        cnt_clear = 1'b1;
                    end
                end
            endcase
        end

        if ((state == ST_RUN) && !abort_now) begin
            if (cpu_halted) begin
                state_nxt = ST_HALTED;
                done_nxt  = 1'b1;
            end else if (bkpt_hit) begin
                state_nxt = ST_PAUSED;
            end else if (cycles >= LIMIT_M1) begin
                state_nxt   = ST_PAUSED;
                timeout_nxt = 1'b1;
            end
        end else if (state == ST_STEP) begin
            state_nxt = ST_PAUSED;
        end else if ((state == ST_PAUSED) && !accept && cpu_halted) begin
            state_nxt = ST_HALTED;
            done_nxt  = 1'b1;
        end
    end

    // state, load pointer and all registered host/memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            mem_we  <= we_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            timeout <= timeout_nxt;
            if (we_nxt) begin
                mem_addr  <= ptr;
                mem_wdata <= cmd_data;
            end
        end
    end

    borus_sat_counter #(
        .CYC_W (CYC_W)
    ) u_cycles (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cpu_ce),
        .count  (cycles)
    );

endmodule

// File: tb/tb_borus_run_ctrl.sv
// Directed self-checking bench for borus_run_ctrl with a tiny core model
// that advances its pc on each enabled cycle and halts at a chosen count.
module tb_borus_run_ctrl;

    localparam int ADDR_W = 4;
    localparam int CYC_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [7:0]        cmd_data = 8'd0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              cpu_ce;
    logic              cpu_halted;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err;
    logic [CYC_W-1:0]  cycles;
    logic [7:0]        pc;
    int                halt_at = 1000;
    int                checks = 0;
    int                errors = 0;
`ifdef BORUS_RUN_CTRL_BKPT_EN
    logic [7:0]        bkpt_addr = 8'd0;
    logic              bkpt_on = 1'b0;
`endif

    borus_run_ctrl #(
        .PROG_DEPTH (16),
        .ADDR_W     (ADDR_W),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .cpu_ce     (cpu_ce),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .err        (err),
        .cycles     (cycles)
`ifdef BORUS_RUN_CTRL_BKPT_EN
        ,
        .cpu_pc     (pc),
        .bkpt_addr  (bkpt_addr),
        .bkpt_on    (bkpt_on)
`endif
    );

    always #5 clk = ~clk;

    // core model: one instruction per enabled cycle, halts after halt_at instructions
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= 8'd0;
            cpu_halted <= 1'b0;
        end else if (cpu_rst) begin
            pc         <= 8'd0;
            cpu_halted <= 1'b0;
        end else if (cpu_ce) begin
            pc <= pc + 8'd1;
            if (int'(pc) + 1 == halt_at) cpu_halted <= 1'b1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // present one command and return #1 after the edge that accepts it
    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_output("cmd_accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [5];
        int ce_cnt;
        int done_cnt;
        prog = '{8'h05, 8'h16, 8'h20, 8'h60, 8'hF0};

        // reset values
        #12;
        check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_cycles", 32'(cycles), 32'd0);
        check_output("rst_flags", {29'd0, done, timeout, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // test 1: five back-to-back loads
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'd0, prog[i]);
            check_output($sformatf("load%0d_we", i), 32'(mem_we), 32'd1);
            check_output($sformatf("load%0d_addr", i), 32'(mem_addr), 32'(i));
            check_output($sformatf("load%0d_data", i), 32'(mem_wdata), 32'(prog[i]));
            check_output($sformatf("load%0d_cpu_rst", i), 32'(cpu_rst), 32'd1);
        end
        @(posedge clk);
        #1;
        check_output("load_we_drop", 32'(mem_we), 32'd0);

        // test 2: run to halt after five instructions
        halt_at = 5;
        apply_stimulus(2'd1, 8'd0);
        check_output("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check_output("run_busy", 32'(busy), 32'd1);
        ce_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ce_cnt += int'(cpu_ce);
            done_cnt += int'(done);
        end
        check_output("run_ce_count", 32'(ce_cnt), 32'd5);
        check_output("run_done_count", 32'(done_cnt), 32'd1);
        check_output("run_cycles", 32'(cycles), 32'd5);
        check_output("run_halted_busy", 32'(busy), 32'd0);

        // test 3: endless loop times out at 8 cycles, STEP clears timeout
        apply_stimulus(2'd3, 8'd0);
        check_output("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("abort_cycles", 32'(cycles), 32'd0);
        halt_at = 1000;
        apply_stimulus(2'd0, 8'h70);
        check_output("jmp_addr", 32'(mem_addr), 32'd0);
        apply_stimulus(2'd1, 8'd0);
        ce_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ce_cnt += int'(cpu_ce);
        end
        check_output("to_ce_count", 32'(ce_cnt), 32'd8);
        check_output("to_timeout", 32'(timeout), 32'd1);
        check_output("to_cycles", 32'(cycles), 32'd8);
        check_output("to_busy", 32'(busy), 32'd0);
        apply_stimulus(2'd2, 8'd0);
        check_output("to_step_clear", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        check_output("to_step_cycles", 32'(cycles), 32'd9);

        // test 4: three single steps from IDLE
        apply_stimulus(2'd3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(2'd2, 8'd0);
            check_output($sformatf("step%0d_ce", i), 32'(cpu_ce), 32'd1);
            check_output($sformatf("step%0d_ready", i), 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("step%0d_ce_off", i), 32'(cpu_ce), 32'd0);
        end
        check_output("step_cycles", 32'(cycles), 32'd3);

        // test 5: halt via step, illegal RUN, abort, pointer wrap
        halt_at = 4;
        apply_stimulus(2'd2, 8'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check_output("step_halt_done", 32'(done_cnt), 32'd1);
        apply_stimulus(2'd1, 8'd0);
        check_output("halted_run_err", 32'(err), 32'd1);
        check_output("halted_run_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_output("halted_err_pulse", 32'(err), 32'd0);
        check_output("halted_stays", {30'd0, cpu_rst, cpu_ce}, 32'd0);
        apply_stimulus(2'd3, 8'd0);
        check_output("abort2_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("abort2_cycles", 32'(cycles), 32'd0);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(2'd0, 8'(8'hA0 + i));
            check_output($sformatf("wrap%0d_addr", i), 32'(mem_addr), 32'(i % 16));
        end
        check_output("wrap_data", 32'(mem_wdata), 32'h00B0);

        // test 6: asynchronous reset in the middle of a run
        halt_at = 1000;
        apply_stimulus(2'd1, 8'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("arst_cpu_ce", 32'(cpu_ce), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_cycles", 32'(cycles), 32'd0);
        check_output("arst_mem", {23'd0, mem_we, mem_addr, 4'd0}, 32'd0);
        check_output("arst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BORUS_RUN_CTRL_BKPT_EN
        // breakpoint at address 2 pauses before executing it, resume executes it
        bkpt_on   = 1'b1;
        bkpt_addr = 8'd2;
        apply_stimulus(2'd1, 8'd0);
        repeat (10) @(negedge clk);
        check_output("bkpt_busy", 32'(busy), 32'd0);
        check_output("bkpt_cycles", 32'(cycles), 32'd2);
        check_output("bkpt_timeout", 32'(timeout), 32'd0);
        apply_stimulus(2'd1, 8'd0);
        check_output("bkpt_resume_ce", 32'(cpu_ce), 32'd1);
        apply_stimulus(2'd3, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
